// File: rtl/td4_core_param.sv
// Single-cycle accumulator CPU core with W-bit data, immediate and PC.
// Instructions are fetched from an external asynchronous ROM at IM_ADDR = PC.
module td4_core_param #(
  parameter int W = 4
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           EN,
  output logic [W-1:0]   IM_ADDR,
  input  logic [W+3:0]   IM_DATA,
  input  logic [W-1:0]   IN_PORT,
  output logic [W-1:0]   OUT_PORT,
  output logic [W-1:0]   A_OUT,
  output logic [W-1:0]   B_OUT,
  output logic           CARRY,
  output logic           HALT
);

  typedef enum logic [3:0] {
    OP_ADD_AI = 4'h0, OP_MOV_AB = 4'h1, OP_IN_A  = 4'h2, OP_MOV_AI = 4'h3,
    OP_MOV_BA = 4'h4, OP_ADD_BI = 4'h5, OP_IN_B  = 4'h6, OP_MOV_BI = 4'h7,
    OP_ADD_AB = 4'h8, OP_OUT_B  = 4'h9, OP_NOP   = 4'hA, OP_OUT_I  = 4'hB,
    OP_JC     = 4'hC, OP_HALT   = 4'hD, OP_JNC   = 4'hE, OP_JMP    = 4'hF
  } op_t;

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] pc_reg, pc_next;
  logic [W-1:0] a_reg, a_next;
  logic [W-1:0] b_reg, b_next;
  logic [W-1:0] out_reg, out_next;
  logic         c_reg, c_next;
  logic         halt_reg, halt_next;

  op_t          op;
  logic [W-1:0] imm;
  logic [W-1:0] add_x, add_y;
  logic [W:0]   sum;

  assign op  = op_t'(IM_DATA[W+3:W]);
  assign imm = IM_DATA[W-1:0];

  // One shared adder; operands steered by opcode.
  assign add_x = (op == OP_ADD_BI) ? b_reg : a_reg;
  assign add_y = (op == OP_ADD_AB) ? b_reg : imm;
  assign sum   = {1'b0, add_x} + {1'b0, add_y};

  always_comb begin
    pc_next   = pc_reg + ONE;
    a_next    = a_reg;
    b_next    = b_reg;
    out_next  = out_reg;
    c_next    = 1'b0;
    halt_next = halt_reg;
    case (op)
      OP_ADD_AI: begin a_next = sum[W-1:0]; c_next = sum[W]; end
      OP_MOV_AB: a_next = b_reg;
      OP_IN_A:   a_next = IN_PORT;
      OP_MOV_AI: a_next = imm;
      OP_MOV_BA: b_next = a_reg;
      OP_ADD_BI: begin b_next = sum[W-1:0]; c_next = sum[W]; end
      OP_IN_B:   b_next = IN_PORT;
      OP_MOV_BI: b_next = imm;
      OP_ADD_AB: begin a_next = sum[W-1:0]; c_next = sum[W]; end
      OP_OUT_B:  out_next = b_reg;
      OP_NOP:    ;
      OP_OUT_I:  out_next = imm;
      // Conditional jumps test the carry left by the previous instruction.
      OP_JC:     if (c_reg) pc_next = imm;
      OP_HALT:   begin pc_next = pc_reg; halt_next = 1'b1; end
      OP_JNC:    if (!c_reg) pc_next = imm;
      OP_JMP:    pc_next = imm;
      default:   ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      pc_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      out_reg  <= '0;
      c_reg    <= 1'b0;
      halt_reg <= 1'b0;
    end else if (EN && !halt_reg) begin
      pc_reg   <= pc_next;
      a_reg    <= a_next;
      b_reg    <= b_next;
      out_reg  <= out_next;
      c_reg    <= c_next;
      halt_reg <= halt_next;
    end
  end

  assign IM_ADDR  = pc_reg;
  assign OUT_PORT = out_reg;
  assign A_OUT    = a_reg;
  assign B_OUT    = b_reg;
  assign CARRY    = c_reg;
  assign HALT     = halt_reg;

endmodule

// File: tb/tb_td4_core_param.sv
// Directed bench for td4_core_param: a W=4 instance runs the hand-coded
// programs, a W=8 instance checks the wide carry case.
module tb_td4_core_param;

  logic        ck = 1'b0;
  logic        rst, en, rst8, en8;
  logic [3:0]  im_addr4, in_port4, out_port4, a4, b4;
  logic [7:0]  im_data4;
  logic        carry4, halt4;
  logic [7:0]  im_addr8, in_port8, out_port8, a8, b8;
  logic [11:0] im_data8;
  logic        carry8, halt8;

  logic [7:0]  rom4 [16];
  logic [11:0] rom8 [256];
  logic        rand_mode;
  logic [7:0]  rand_word;

  int passes = 0;
  int total  = 0;

  always #5 ck = ~ck;

  always_comb im_data4 = rand_mode ? rand_word : rom4[im_addr4];
  always_comb im_data8 = rom8[im_addr8];

  td4_core_param #(.W(4)) dut4 (
    .CK(ck), .RST(rst), .EN(en), .IM_ADDR(im_addr4), .IM_DATA(im_data4),
    .IN_PORT(in_port4), .OUT_PORT(out_port4), .A_OUT(a4), .B_OUT(b4),
    .CARRY(carry4), .HALT(halt4)
  );

  td4_core_param #(.W(8)) dut8 (
    .CK(ck), .RST(rst8), .EN(en8), .IM_ADDR(im_addr8), .IM_DATA(im_data8),
    .IN_PORT(in_port8), .OUT_PORT(out_port8), .A_OUT(a8), .B_OUT(b8),
    .CARRY(carry8), .HALT(halt8)
  );

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] pc, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] o, input logic c, input logic h);
    chk({tag, ".pc"},   16'(im_addr4),  16'(pc));
    chk({tag, ".a"},    16'(a4),        16'(a));
    chk({tag, ".b"},    16'(b4),        16'(b));
    chk({tag, ".out"},  16'(out_port4), 16'(o));
    chk({tag, ".c"},    16'(carry4),    16'(c));
    chk({tag, ".halt"}, 16'(halt4),     16'(h));
    $display("step %s: pc=%0h a=%0h b=%0h out=%0h c=%0b halt=%0b",
             tag, im_addr4, a4, b4, out_port4, carry4, halt4);
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) rom4[i] = 8'hA0;
  endtask

  task automatic reset4();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rst8 = 1'b1; en8 = 1'b1;
    in_port4 = 4'h0; in_port8 = 8'h00;
    rand_mode = 1'b1; rand_word = 8'h3F;
    load_nops();
    for (int i = 0; i < 256; i++) rom8[i] = 12'hA00;

    // 1. Reset held two cycles with MOV A,0xF presented
    step(); step();
    chk4("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // 2. Carry and JC
    rand_mode = 1'b0;
    rom4[0] = 8'h33; rom4[1] = 8'h0E; rom4[2] = 8'hC5;
    reset4();
    step(); chk4("jc.mov",  4'h1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0);
    step(); chk4("jc.add",  4'h2, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
    step(); chk4("jc.jump", 4'h5, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0);

    // 3. Counting loop closed by JNC
    load_nops();
    rom4[0] = 8'h01; rom4[1] = 8'hE0;
    reset4();
    for (int k = 1; k < 16; k++) begin
      step(); chk4("loop.add", 4'h1, 4'(k), 4'h0, 4'h0, 1'b0, 1'b0);
      step(); chk4("loop.jnc", 4'h0, 4'(k), 4'h0, 4'h0, 1'b0, 1'b0);
    end
    step(); chk4("loop.wrap", 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    step(); chk4("loop.fall", 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // 4. Input and output ports
    load_nops();
    in_port4 = 4'hA;
    rom4[0] = 8'h37; rom4[1] = 8'h60; rom4[2] = 8'h80; rom4[3] = 8'h90;
    reset4();
    step(); chk4("io.mov", 4'h1, 4'h7, 4'h0, 4'h0, 1'b0, 1'b0);
    step(); chk4("io.in",  4'h2, 4'h7, 4'hA, 4'h0, 1'b0, 1'b0);
    step(); chk4("io.add", 4'h3, 4'h1, 4'hA, 4'h0, 1'b1, 1'b0);
    step(); chk4("io.out", 4'h4, 4'h1, 4'hA, 4'hA, 1'b0, 1'b0);

    // 6a. Enable dropped mid-program, then resumes at the same PC
    reset4();
    step(); step();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(); chk4("en.hold", 4'h2, 4'h7, 4'hA, 4'h0, 1'b0, 1'b0);
    end
    en = 1'b1;
    step(); chk4("en.resume", 4'h3, 4'h1, 4'hA, 4'h0, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk4("rst.mid", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // 5. Sticky HALT at address 3
    load_nops();
    rom4[3] = 8'hD0;
    reset4();
    step(); step(); step();
    chk4("halt.pre", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(); chk4("halt.set", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    rand_mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_word = 8'($urandom);
      en = 1'($urandom);
      step(); chk4("halt.hold", 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    end
    en = 1'b1; rand_mode = 1'b0;
    rst = 1'b1;
    step(); chk4("halt.rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // 6b. JMP to last address, PC wraps to 0
    load_nops();
    rom4[0] = 8'hFF; rom4[15] = 8'hA0;
    reset4();
    step(); chk4("wrap.jmp", 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(); chk4("wrap.pc0", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // 6c. W=8: 1 + 0xFF carries out
    rom8[0] = 12'h301; rom8[1] = 12'h0FF;
    rst8 = 1'b1; step(); rst8 = 1'b0;
    step();
    chk("w8.mov.a", 16'(a8), 16'h0001);
    chk("w8.mov.c", 16'(carry8), 16'h0000);
    $display("step w8.mov: pc=%0h a=%0h c=%0b", im_addr8, a8, carry8);
    step();
    chk("w8.add.a",  16'(a8), 16'h0000);
    chk("w8.add.c",  16'(carry8), 16'h0001);
    chk("w8.add.pc", 16'(im_addr8), 16'h0002);
    $display("step w8.add: pc=%0h a=%0h c=%0b", im_addr8, a8, carry8);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/td4_core_param.md
# td4_core_param

Parametrised single-cycle accumulator CPU core, the next generation of the team's 4-bit TD4-style processor. Data width, immediate width and program-counter width are all set by `W`. Program memory is external, behind a fetch port, rather than hard-wired. Compared with the fixed-width core it adds an input port, register-to-register add, conditional jump on carry, NOP, a sticky HALT, and a run enable. The core sits between an external instruction ROM and the board-level I/O registers.

## Interface
- `W`, default 4: data, immediate and PC width; legal range 4..16. Program depth is 2^W words.
- `CK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `EN` in 1: run enable; when 0, all state holds.
- `IM_ADDR` out W: fetch address; equals the PC register.
- `IM_DATA` in 4+W: instruction word, `{OP[3:0], IMM[W-1:0]}`, from the external ROM (asynchronous read).
- `IN_PORT` in W: external input value, sampled by the IN instructions.
- `OUT_PORT` out W: registered output port.
- `A_OUT` out W: register A, for debug.
- `B_OUT` out W: register B, for debug.
- `CARRY` out 1: carry flag C.
- `HALT` out 1: sticky halt flag.

## Operation
- **Reset.** State registers are PC, A, B, OUT, C and HALT. On a rising edge with RST=1, all of them become 0. RST takes priority over EN and over HALT.
- **Execute condition.** An instruction executes on a rising edge when RST=0, EN=1 and HALT=0. Otherwise every register holds its value.
- **Instruction cycle.** Each instruction takes exactly one cycle. The default next PC is PC+1 mod 2^W.
- **Arithmetic.** All adds are (W+1)-bit. The destination register receives `sum[W-1:0]`; C receives `sum[W]`.
- **Carry rule.** ADD instructions write C with their carry-out. Every other executed instruction writes C=0, including jumps, which read the old C before clearing it.
- **Opcodes:**
  - 0x0 ADD A,IMM: A <= A+IMM.
  - 0x1 MOV A,B: A <= B.
  - 0x2 IN A: A <= IN_PORT.
  - 0x3 MOV A,IMM: A <= IMM.
  - 0x4 MOV B,A: B <= A.
  - 0x5 ADD B,IMM: B <= B+IMM.
  - 0x6 IN B: B <= IN_PORT.
  - 0x7 MOV B,IMM: B <= IMM.
  - 0x8 ADD A,B: A <= A+B.
  - 0x9 OUT B: OUT <= B.
  - 0xA NOP: no register change other than PC and C.
  - 0xB OUT IMM: OUT <= IMM.
  - 0xC JC IMM: PC <= IMM if C=1, else PC+1.
  - 0xD HALT: PC holds its current value; HALT <= 1.
  - 0xE JNC IMM: PC <= IMM if C=0, else PC+1.
  - 0xF JMP IMM: PC <= IMM unconditionally.
- **Halted state.** Once HALT=1, only RST changes state. EN and IM_DATA are ignored.
- **Out-of-range immediates.** Jump targets are the full W-bit IMM, so no target is out of range. PC wraps from 2^W-1 to 0.

## Timing
- `IM_ADDR` is driven directly from the PC flop with no combinational path from inputs. `IM_DATA` must settle within the same cycle.
- `IN_PORT` is sampled at the executing edge.
- Results are visible on `A_OUT`, `B_OUT`, `OUT_PORT`, `CARRY`, `HALT` and `IM_ADDR` immediately after the executing edge (one-cycle latency).
- Fetch-to-execute throughput is one instruction per enabled cycle, with no pipeline hazards.
- **EN deasserted mid-program:** the instruction at the current PC executes on the first edge with EN=1.
- **RST asserted mid-instruction:** the same edge yields the reset state; the pending instruction is discarded.
- **RST and EN both high:** reset wins.

## Test plan
1. **Reset.** Hold RST=1 for 2 cycles with EN=1 and IM_DATA=0x3F. Required: PC=0, A=B=OUT=0, C=0, HALT=0.
2. **Carry and JC.** Program (W=4): 0x33, 0x0E, 0xC5. Required: A=3, then A=1 with C=1, then PC=5 with C=0.
3. **Loop with JNC.** Program: 0x01, 0xE0. Required: A counts 1..15 with PC alternating between 0 and 1. When A wraps 15 to 0, C=1 and JNC falls through to PC=2.
4. **Input and output ports.** Set IN_PORT=0xA. Program: 0x37, 0x60, 0x80, 0x90. Required: B=0xA; then A=0x1 with C=1; then OUT_PORT=0xA with C=0.
5. **HALT.** Place 0xD0 at address 3. Required: PC stays 3 and HALT=1 over 10 cycles while EN toggles and IM_DATA is randomised. A subsequent RST returns everything to 0.
6. **Enable hold, PC wrap, wide instance.**
   - Drop EN for 5 cycles mid-program. Required: all outputs frozen.
   - Program 0xFF at address 0 (JMP 15), then 0xA0 at address 15. Required: PC goes 15, then 0.
   - W=8 instance: A=1, then ADD A,0xFF. Required: A=0x00, C=1.
